// File: rtl/terrain_pkg.sv
// Shared constants, state encoding and column type for the terrain crater carving logic.
package terrain_pkg;

   localparam int NCOLS = 640;
   localparam int NROWS = 480;
   localparam int MAX_R = 63;

   typedef logic [NROWS-1:0] col_t;

   localparam col_t COL_ONES = '1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      READ,
      WAIT,
      SQRT,
      WRITE,
      NEXT,
      FINISH
   } crater_state_t;

   function automatic logic [5:0] sat_radius(input logic [5:0] r);
      return (int'(r) > MAX_R) ? 6'(MAX_R) : r;
   endfunction

endpackage

// File: rtl/crater_isqrt.sv
// Sequential integer square root: h = floor(sqrt(hsq)), one increment per cycle.
// valid rises in the cycle where (h+1)^2 would exceed hsq, so a result of h takes h+1 cycles.
module crater_isqrt (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] hsq,
   output logic [5:0]  h,
   output logic        valid
);

   logic [11:0] hsq_q;
   logic        running;
   logic [6:0]  h_next;
   logic [13:0] h_next_sq;
   logic        step_ok;

   always_comb begin
      h_next    = {1'b0, h} + 7'd1;
      h_next_sq = {7'b0, h_next} * {7'b0, h_next};
      step_ok   = h_next_sq <= {2'b0, hsq_q};
      valid     = running && !step_ok;
   end

   // h holds its final value after valid until the next start
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h       <= '0;
         hsq_q   <= '0;
         running <= 1'b0;
      end else if (start) begin
         h       <= '0;
         hsq_q   <= hsq;
         running <= 1'b1;
      end else if (running) begin
         if (step_ok)
            h <= h_next[5:0];
         else
            running <= 1'b0;
      end
   end

endmodule

// File: rtl/terrain_crater.sv
// Carves a filled circle out of the terrain column store, one read-modify-write per column.
module terrain_crater
   import terrain_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        terrain_rdy,
   input  logic        req,
   input  logic [9:0]  cx,
   input  logic [9:0]  cy,
   input  logic [5:0]  radius,
   output logic        busy,
   output logic        done,
   output logic        hit,
   output logic [9:0]  rd_addr,
   input  col_t        rd_data,
   output logic        we,
   output logic [9:0]  wr_addr,
   output col_t        wr_data
);

   crater_state_t state_q;
   logic [9:0]    cx_q, cy_q, col_q, x_hi_q;
   logic [5:0]    r_q;
   col_t          column_q;

   logic signed [10:0] x_diff;
   logic [10:0]        x_sum, y_sum;
   logic [9:0]         x_lo, x_hi, y_lo, y_hi;
   logic [5:0]         dx_abs;
   logic [11:0]        hsq;
   logic               y_empty;
   col_t               mask;

   logic       sq_start, sq_valid;
   logic [5:0] sq_h;

   crater_isqrt u_isqrt (
      .clk   (clk),
      .reset (reset),
      .start (sq_start),
      .hsq   (hsq),
      .h     (sq_h),
      .valid (sq_valid)
   );

   // Column range, half-chord height and row mask, all clipped to the terrain bounds
   always_comb begin
      x_diff   = $signed({1'b0, cx_q}) - $signed({5'b0, r_q});
      x_lo     = x_diff[10] ? 10'd0 : x_diff[9:0];
      x_sum    = {1'b0, cx_q} + {5'b0, r_q};
      x_hi     = (x_sum > 11'(NCOLS - 1)) ? 10'(NCOLS - 1) : x_sum[9:0];
      dx_abs   = (col_q >= cx_q) ? 6'(col_q - cx_q) : 6'(cx_q - col_q);
      hsq      = ({6'b0, r_q} * {6'b0, r_q}) - ({6'b0, dx_abs} * {6'b0, dx_abs});
      sq_start = (state_q == WAIT);
      y_lo     = (cy_q < {4'b0, sq_h}) ? 10'd0 : (cy_q - {4'b0, sq_h});
      y_sum    = {1'b0, cy_q} + {5'b0, sq_h};
      y_hi     = (y_sum > 11'(NROWS - 1)) ? 10'(NROWS - 1) : y_sum[9:0];
      y_empty  = y_lo > 10'(NROWS - 1);
      mask     = y_empty ? '0 : ((COL_ONES << y_lo) & (COL_ONES >> (10'(NROWS - 1) - y_hi)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cx_q     <= '0;
         cy_q     <= '0;
         r_q      <= '0;
         col_q    <= '0;
         x_hi_q   <= '0;
         column_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hit      <= 1'b0;
         we       <= 1'b0;
         rd_addr  <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req && terrain_rdy) begin
                  cx_q    <= cx;
                  cy_q    <= cy;
                  r_q     <= sat_radius(radius);
                  busy    <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               hit <= 1'b0;
               if (int'(cx_q) >= NCOLS) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= FINISH;
               end else begin
                  col_q   <= x_lo;
                  x_hi_q  <= x_hi;
                  rd_addr <= x_lo;
                  state_q <= READ;
               end
            end
            READ: state_q <= WAIT;
            WAIT: begin
               column_q <= rd_data;
               state_q  <= SQRT;
            end
            SQRT: begin
               if (sq_valid) begin
                  we      <= 1'b1;
                  wr_addr <= col_q;
                  wr_data <= column_q & ~mask;
                  hit     <= hit | (|(column_q & mask));
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               we      <= 1'b0;
               state_q <= NEXT;
            end
            NEXT: begin
               col_q <= col_q + 10'd1;
               if ((col_q + 10'd1) <= x_hi_q) begin
                  rd_addr <= col_q + 10'd1;
                  state_q <= READ;
               end else begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               done    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_terrain_crater.sv
// Directed bench for terrain_crater: an SRAM model feeds the DUT and a circle model fills a write scoreboard.
module tb_terrain_crater;
   import terrain_pkg::*;

   localparam col_t FLAT = COL_ONES << 310;

   typedef struct {
      logic [9:0] addr;
      col_t       data;
   } wr_item_t;

   logic       clk = 1'b0;
   logic       reset, terrain_rdy, req, load_mem;
   logic [9:0] cx, cy;
   logic [5:0] radius;
   logic       busy, done, hit, we;
   logic [9:0] rd_addr, wr_addr;
   col_t       rd_data, wr_data;

   col_t     mem [0:NCOLS-1];
   col_t     ref_mem [0:NCOLS-1];
   wr_item_t sb [$];
   int       n_assert = 0;
   int       n_fail = 0;
   int       n_writes = 0;
   int       cycles, w0;
   logic     exp_hit;

   terrain_crater dut (
      .clk         (clk),
      .reset       (reset),
      .terrain_rdy (terrain_rdy),
      .req         (req),
      .cx          (cx),
      .cy          (cy),
      .radius      (radius),
      .busy        (busy),
      .done        (done),
      .hit         (hit),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .we          (we),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   always #5 clk = ~clk;

   // Registered-read terrain store
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (load_mem) begin
         for (int i = 0; i < NCOLS; i++) mem[i] <= FLAT;
      end else if (we && (int'(wr_addr) < NCOLS)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   task automatic checkOutput(input string tag, input logic [479:0] obs, input logic [479:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every write strobe must match the next expected column
   always @(negedge clk) begin
      if (reset === 1'b1 && we === 1'b1) begin
         wr_item_t item;
         n_writes++;
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("[TB] FAIL unexpected_write: observed write to col %0d expected no write", wr_addr);
         end
         if (sb.size() != 0) begin
            item = sb.pop_front();
            checkOutput("wr_addr", 480'(wr_addr), 480'(item.addr));
            checkOutput("wr_data", wr_data, item.data);
         end
      end
   end

   task automatic pulseReq(input int x, input int y, input int r);
      @(negedge clk);
      cx     = 10'(x);
      cy     = 10'(y);
      radius = 6'(r);
      req    = 1'b1;
      @(negedge clk);
      req    = 1'b0;
   endtask

   // Reference: bit (col,row) is cleared iff it lies inside or on the circle
   task automatic applyStimulus(input int x, input int y, input int r);
      int   rs, lo, hi;
      col_t d;
      rs      = (r > MAX_R) ? MAX_R : r;
      exp_hit = 1'b0;
      if (x < NCOLS) begin
         lo = (x - rs < 0) ? 0 : x - rs;
         hi = (x + rs > NCOLS - 1) ? NCOLS - 1 : x + rs;
         for (int c = lo; c <= hi; c++) begin
            d = ref_mem[c];
            for (int row = 0; row < NROWS; row++) begin
               if ((c - x) * (c - x) + (row - y) * (row - y) <= rs * rs) begin
                  if (d[row]) exp_hit = 1'b1;
                  d[row] = 1'b0;
               end
            end
            ref_mem[c] = d;
            sb.push_back('{addr: 10'(c), data: d});
         end
      end
      pulseReq(x, y, r);
   endtask

   task automatic waitDone(input int limit, output int n);
      n = 1;
      while (done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_seen", 480'(done), 480'(1));
   endtask

   task automatic finishCheck();
      checkOutput("hit", 480'(hit), 480'(exp_hit));
      checkOutput("busy_at_done", 480'(busy), 480'(0));
      checkOutput("sb_drained", 480'(sb.size()), 480'(0));
   endtask

   initial begin
      reset = 1'b0;
      terrain_rdy = 1'b0;
      req = 1'b0;
      load_mem = 1'b1;
      cx = '0;
      cy = '0;
      radius = '0;
      for (int i = 0; i < NCOLS; i++) ref_mem[i] = FLAT;
      repeat (2) @(negedge clk);
      load_mem = 1'b0;
      checkOutput("rst_busy", 480'(busy), 480'(0));
      checkOutput("rst_done", 480'(done), 480'(0));
      checkOutput("rst_hit", 480'(hit), 480'(0));
      checkOutput("rst_we", 480'(we), 480'(0));
      checkOutput("rst_rd_addr", 480'(rd_addr), 480'(0));
      checkOutput("rst_wr_addr", 480'(wr_addr), 480'(0));
      checkOutput("rst_wr_data", wr_data, 480'(0));
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] request while terrain not ready");
      pulseReq(100, 310, 10);
      repeat (4) @(negedge clk);
      checkOutput("not_rdy_busy", 480'(busy), 480'(0));
      terrain_rdy = 1'b1;

      $display("[TB] flat terrain crater");
      applyStimulus(100, 310, 10);
      checkOutput("busy_after_req", 480'(busy), 480'(1));
      waitDone(3000, cycles);
      finishCheck();
      checkOutput("s1_hit", 480'(hit), 480'(1));
      @(negedge clk);
      checkOutput("col100_hole", 480'(mem[100][320:300]), 480'(0));
      checkOutput("col100_below", 480'(mem[100][321]), 480'(1));
      checkOutput("col90_bit310", 480'(mem[90][310]), 480'(0));
      checkOutput("col90_bit311", 480'(mem[90][311]), 480'(1));
      checkOutput("col111_intact", mem[111], FLAT);

      $display("[TB] zero radius");
      applyStimulus(5, 400, 0);
      waitDone(200, cycles);
      checkOutput("r0_latency", 480'(cycles), 480'(7));
      finishCheck();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      checkOutput("req_at_finish_ignored", 480'(busy), 480'(0));
      @(negedge clk);
      checkOutput("r0_bit400", 480'(mem[5][400]), 480'(0));
      checkOutput("r0_bit401", 480'(mem[5][401]), 480'(1));

      $display("[TB] edge clipping");
      applyStimulus(2, 475, 8);
      waitDone(3000, cycles);
      finishCheck();

      $display("[TB] crater in air");
      applyStimulus(320, 100, 20);
      waitDone(5000, cycles);
      finishCheck();
      checkOutput("air_hit", 480'(hit), 480'(0));

      $display("[TB] request while busy");
      applyStimulus(400, 310, 3);
      repeat (10) @(negedge clk);
      pulseReq(450, 320, 5);
      waitDone(1000, cycles);
      finishCheck();
      repeat (5) @(negedge clk);
      checkOutput("idle_after_busy_req", 480'(busy), 480'(0));

      $display("[TB] centre off the right edge");
      applyStimulus(700, 310, 5);
      waitDone(50, cycles);
      checkOutput("offmap_latency", 480'(cycles), 480'(2));
      checkOutput("offmap_hit", 480'(hit), 480'(0));
      finishCheck();

      $display("[TB] reset during third column");
      w0 = n_writes;
      applyStimulus(500, 310, 10);
      cycles = 0;
      while (n_writes < w0 + 2 && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("two_writes_before_reset", 480'(n_writes - w0), 480'(2));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("async_rst_we", 480'(we), 480'(0));
      checkOutput("async_rst_busy", 480'(busy), 480'(0));
      checkOutput("async_rst_done", 480'(done), 480'(0));
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_after_reset", 480'(busy), 480'(0));
      applyStimulus(200, 320, 5);
      checkOutput("busy_after_reset_req", 480'(busy), 480'(1));
      waitDone(2000, cycles);
      finishCheck();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
